// File: rtl/structure2_fc1fc2_pingpong_ctrl_pkg.sv
// Shared constants and bank type for the structure-2 FC1->FC2 ping-pong buffer.
package structure2_fc1fc2_pingpong_ctrl_pkg;

  localparam int DATA_W      = 18;
  localparam int ADDR_W      = 14;
  localparam int BANK_AW     = ADDR_W - 1;
  localparam int NUM_NEURONS = 128;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/structure2_fc1fc2_pingpong_ctrl.sv
// Ping-pong bank controller: FC1 fills one half of the dual-port buffer while
// FC2 drains the other; banks are handed over strictly in fill order.
module structure2_fc1fc2_pingpong_ctrl #(
  parameter int DATA_W      = structure2_fc1fc2_pingpong_ctrl_pkg::DATA_W,
  parameter int ADDR_W      = structure2_fc1fc2_pingpong_ctrl_pkg::ADDR_W,
  parameter int NUM_NEURONS = structure2_fc1fc2_pingpong_ctrl_pkg::NUM_NEURONS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fc1_valid,
  input  logic [DATA_W-1:0] fc1_data,
  output logic              fc1_ready,
  input  logic              fc2_req,
  output logic              fc2_avail,
  output logic [DATA_W-1:0] fc2_data,
  output logic              fc2_dvalid,
  output logic              fc2_last,
  output logic              frame_done,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
);

  import structure2_fc1fc2_pingpong_ctrl_pkg::*;

  localparam int CNT_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NEURONS - 1);

  logic [1:0]       full;
  logic [1:0]       full_nxt;
  bank_e            wr_bank;
  bank_e            rd_bank;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             wr_acc;
  logic             rd_acc;
  logic             wr_last;
  logic             rd_last;
  logic             rd_last_q;

  assign fc1_ready = !full[wr_bank];
  assign fc2_avail = full[rd_bank];
  assign wr_acc    = fc1_valid && fc1_ready;
  assign rd_acc    = fc2_req && fc2_avail;
  assign wr_last   = wr_acc && (wr_cnt == LAST_CNT);
  assign rd_last   = rd_acc && (rd_cnt == LAST_CNT);
  assign fc2_data  = bram_doutb;

  // A bank filling and the other draining in the same cycle must both land.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= 2'b00;
    else        full <= full_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= BANK0;
      wr_cnt     <= '0;
      bram_wea   <= 1'b0;
      bram_addra <= '0;
      bram_dina  <= '0;
    end else begin
      bram_wea <= wr_acc;
      if (wr_acc) begin
        bram_addra <= {wr_bank, wr_cnt};
        bram_dina  <= fc1_data;
        if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= other_bank(wr_bank);
        end else begin
          wr_cnt <= wr_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank    <= BANK0;
      rd_cnt     <= '0;
      bram_enb   <= 1'b0;
      bram_addrb <= '0;
      frame_done <= 1'b0;
    end else begin
      bram_enb   <= rd_acc;
      frame_done <= rd_last;
      if (rd_acc) begin
        bram_addrb <= {rd_bank, rd_cnt};
        if (rd_last) begin
          rd_cnt  <= '0;
          rd_bank <= other_bank(rd_bank);
        end else begin
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Data-valid tracks the read request through the BRAM's one-cycle latency,
  // independent of any bank state change that happens meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_last_q  <= 1'b0;
      fc2_dvalid <= 1'b0;
      fc2_last   <= 1'b0;
    end else begin
      rd_last_q  <= rd_last;
      fc2_dvalid <= bram_enb;
      fc2_last   <= rd_last_q;
    end
  end

endmodule

// File: tb/tb_structure2_fc1fc2_pingpong_ctrl.sv
// Randomized self-checking bench for the FC1/FC2 ping-pong controller with a
// frame-counting reference model and a behavioural dual-port BRAM.
module tb_structure2_fc1fc2_pingpong_ctrl;

  localparam int DW = 18;
  localparam int AW = 14;
  localparam int NN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fc1_valid = 1'b0;
  logic [DW-1:0] fc1_data = '0;
  logic          fc1_ready;
  logic          fc2_req = 1'b0;
  logic          fc2_avail;
  logic [DW-1:0] fc2_data;
  logic          fc2_dvalid;
  logic          fc2_last;
  logic          frame_done;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;
  logic          bram_enb;
  logic [AW-1:0] bram_addrb;
  logic [DW-1:0] bram_doutb = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;
  int wcount = 0;
  int rcount = 0;
  logic [DW-1:0] data_q[$];
  logic prev_racc = 1'b0;
  int   prev_ridx = 0;

  structure2_fc1fc2_pingpong_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_NEURONS(NN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fc1_valid(fc1_valid), .fc1_data(fc1_data), .fc1_ready(fc1_ready),
    .fc2_req(fc2_req), .fc2_avail(fc2_avail), .fc2_data(fc2_data),
    .fc2_dvalid(fc2_dvalid), .fc2_last(fc2_last), .frame_done(frame_done),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Word n of the stream lives in frame n/NN, which alternates banks.
  function automatic logic [AW-1:0] word_addr(input int n);
    int frame;
    frame = n / NN;
    return AW'(((frame % 2) << (AW - 1)) + (n % NN));
  endfunction

  function automatic int full_frames();
    return (wcount / NN) - (rcount / NN);
  endfunction

  task automatic apply_reset(input int delay);
    #(delay);
    fc1_valid = 1'b0;
    fc2_req   = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++;
    if ({fc1_ready, fc2_avail, bram_wea, bram_enb, fc2_dvalid, fc2_last, frame_done} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 1000000", {fc1_ready, fc2_avail, bram_wea, bram_enb, fc2_dvalid, fc2_last, frame_done});
    end
    checks++;
    if ({bram_addra, bram_addrb} !== '0) begin
      errors++;
      $display("FAIL reset_addr: got addra=%h addrb=%h required 0", bram_addra, bram_addrb);
    end
    checks++;
    if (bram_dina !== '0) begin
      errors++;
      $display("FAIL reset_dina: got %h required 0", bram_dina);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wcount = 0;
    rcount = 0;
    data_q.delete();
    prev_racc = 1'b0;
    prev_ridx = 0;
  endtask

  // One clock of stimulus; called right after a falling edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, output logic wacc);
    logic exp_ready, exp_avail, racc, exp_dv, exp_last, exp_fd;
    logic [AW-1:0] exp_aa, exp_ab;
    logic [DW-1:0] exp_data;
    fc1_valid = v;
    fc1_data  = d;
    fc2_req   = r;
    #1;
    exp_ready = full_frames() < 2;
    exp_avail = full_frames() >= 1;
    checks++;
    if (fc1_ready !== exp_ready) begin
      errors++;
      $display("FAIL fc1_ready: got %b required %b at %0t", fc1_ready, exp_ready, $time);
    end
    checks++;
    if (fc2_avail !== exp_avail) begin
      errors++;
      $display("FAIL fc2_avail: got %b required %b at %0t", fc2_avail, exp_avail, $time);
    end
    wacc     = v && exp_ready;
    racc     = r && exp_avail;
    exp_aa   = word_addr(wcount);
    exp_ab   = word_addr(rcount);
    exp_dv   = prev_racc;
    exp_last = prev_racc && ((prev_ridx % NN) == NN - 1);
    if (wacc) begin
      data_q.push_back(d);
      wcount++;
    end
    if (racc) rcount++;
    exp_fd = racc && ((rcount % NN) == 0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bram_wea !== wacc) begin
      errors++;
      $display("FAIL bram_wea: got %b required %b at %0t", bram_wea, wacc, $time);
    end
    if (wacc) begin
      checks++;
      if (bram_addra !== exp_aa || bram_dina !== d) begin
        errors++;
        $display("FAIL write_port: got addra=%h dina=%h required addra=%h dina=%h", bram_addra, bram_dina, exp_aa, d);
      end
    end
    checks++;
    if (bram_enb !== racc) begin
      errors++;
      $display("FAIL bram_enb: got %b required %b at %0t", bram_enb, racc, $time);
    end
    if (racc) begin
      checks++;
      if (bram_addrb !== exp_ab) begin
        errors++;
        $display("FAIL bram_addrb: got %h required %h", bram_addrb, exp_ab);
      end
    end
    checks++;
    if (frame_done !== exp_fd) begin
      errors++;
      $display("FAIL frame_done: got %b required %b at %0t", frame_done, exp_fd, $time);
    end
    checks++;
    if (fc2_dvalid !== exp_dv || fc2_last !== exp_last) begin
      errors++;
      $display("FAIL dvalid_last: got %b/%b required %b/%b at %0t", fc2_dvalid, fc2_last, exp_dv, exp_last, $time);
    end
    if (exp_dv) begin
      checks++;
      if (data_q.size() == 0) begin
        errors++;
        $display("FAIL fc2_data: got %h required nothing (no word outstanding)", fc2_data);
      end else begin
        exp_data = data_q.pop_front();
        if (fc2_data !== exp_data) begin
          errors++;
          $display("FAIL fc2_data: got %h required %h", fc2_data, exp_data);
        end
      end
    end
    prev_racc = racc;
    prev_ridx = rcount - 1;
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, r, acc);
  endtask

  task automatic test_reset();
    apply_reset(0);
    idle(2, 1'b0);
  endtask

  task automatic test_write_frame();
    logic acc;
    apply_reset(0);
    for (int i = 1; i <= NN; i++) cycle(1'b1, DW'(i), 1'b0, acc);
    idle(1, 1'b0);
  endtask

  task automatic test_read_frame();
    idle(NN, 1'b1);
    idle(3, 1'b0);
  endtask

  task automatic test_both_full();
    logic acc;
    int budget;
    apply_reset(0);
    for (int i = 1; i <= 2 * NN; i++) cycle(1'b1, DW'(i), 1'b0, acc);
    cycle(1'b1, DW'(2 * NN + 1), 1'b0, acc);
    checks++;
    if (acc !== 1'b0 || fc1_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_when_full: got accept=%b ready=%b required 0/0", acc, fc1_ready);
    end
    budget = 0;
    acc = 1'b0;
    while (!acc && budget < 20) begin
      cycle(1'b1, DW'(2 * NN + 1), 1'b1, acc);
      budget++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL stall_release: got no accept in 20 cycles, required accept");
    end
    idle(NN + 3, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic acc;
    int accepted, budget;
    apply_reset(0);
    accepted = 0;
    for (int i = 0; i < 5 * NN; i++) begin
      cycle(1'b1, DW'($urandom()), 1'b1, acc);
      if (acc) accepted++;
    end
    checks++;
    if (accepted != 5 * NN) begin
      errors++;
      $display("FAIL stream_no_stall: got %0d accepts required %0d", accepted, 5 * NN);
    end
    budget = 0;
    while (rcount < wcount && budget < 40) begin
      idle(1, 1'b1);
      budget++;
    end
    idle(3, 1'b0);
    checks++;
    if (data_q.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: got %0d words left required 0", data_q.size());
    end
  endtask

  task automatic test_random();
    logic acc;
    apply_reset(0);
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), DW'($urandom()), 1'($urandom_range(0, 1)), acc);
    idle(2 * NN + 3, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic acc;
    apply_reset(0);
    for (int i = 0; i < 2 * NN; i++) cycle(1'b1, DW'($urandom()), 1'b0, acc);
    idle(NN + 2, 1'b1);
    apply_reset(2);
    idle(1, 1'b1);
    cycle(1'b1, DW'(18'h155), 1'b0, acc);
    idle(1, 1'b0);
  endtask

  task automatic test_req_when_empty();
    logic acc;
    apply_reset(0);
    idle(3, 1'b1);
    for (int i = 0; i < NN; i++) cycle(1'b1, DW'($urandom()), 1'b1, acc);
    idle(NN + 3, 1'b1);
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_read_frame();
    test_both_full();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_req_when_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
